// File: rtl/mlp_cmd_sched_pkg.sv
// Shared types for the mlp_fsm command scheduler.
//   op_e     : host command opcode (INIT weights / RUN inference)
//   err_e    : per-command completion status reported on done_err_o
//   cmd_t    : queued command (opcode + host tag)
//   St*      : scheduler FSM state encodings
package mlp_cmd_sched_pkg;

    typedef enum logic {
        OpInit = 1'b0,
        OpRun  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ErrOk           = 2'd0,
        ErrNoWeights    = 2'd1,
        ErrTimeout      = 2'd2,
        ErrBeatMismatch = 2'd3
    } err_e;

    typedef struct packed {
        op_e        op;
        logic [3:0] tag;
    } cmd_t;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StIssue    = 3'd1;
    localparam logic [2:0] StWaitInit = 3'd2;
    localparam logic [2:0] StWaitRun  = 3'd3;
    localparam logic [2:0] StDone     = 3'd4;

    localparam int BeatW = 9;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [BeatW-1:0] sat_inc(input logic [BeatW-1:0] v);
        return (&v) ? v : v + BeatW'(1);
    endfunction

endpackage

// File: rtl/mlp_cmd_fifo.sv
// Synchronous command FIFO, Depth entries of cmd_t.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write strobe and command (caller guarantees !full_o)
//   pop_i, data_o   : read strobe and head command (caller guarantees !empty_o)
//   full_o, empty_o : occupancy flags
module mlp_cmd_fifo
    import mlp_cmd_sched_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(Depth);

    cmd_t           mem [Depth];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]    wptr, rptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_i) wptr <= wptr + (AW+1)'(1);
            if (pop_i)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr[AW-1:0]] <= data_i;
    end

    assign data_o  = mem[rptr[AW-1:0]];
    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mlp_cmd_sched.sv
// Command scheduler in front of mlp_fsm. Queues host INIT/RUN commands, issues
// them one at a time over the init/start handshakes, tracks completion, result
// beats and weights-loaded state, and reports per-command status.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o/op_i/tag_i: host command push interface
//   init_valid_o / init_ready_i   : INIT handshake to mlp_fsm
//   start_valid_o / start_ready_i : RUN handshake to mlp_fsm
//   result_valid_i                : result beats from mlp_fsm
//   busy_o, weights_ok_o, fault_o : status
//   done_o, done_tag_o, done_err_o: one-cycle completion report
module mlp_cmd_sched
    import mlp_cmd_sched_pkg::*;
#(
    parameter int QDepth        = 4,
    parameter int ResultBeats   = 256,
    parameter int TimeoutCycles = 200000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_op_i,
    input  logic [3:0] cmd_tag_i,
    output logic       init_valid_o,
    input  logic       init_ready_i,
    output logic       start_valid_o,
    input  logic       start_ready_i,
    input  logic       result_valid_i,
    output logic       busy_o,
    output logic       weights_ok_o,
    output logic       fault_o,
    output logic       done_o,
    output logic [3:0] done_tag_o,
    output logic [1:0] done_err_o
);

    localparam int              TW        = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0]   TimerLast = TW'(TimeoutCycles - 1);
    localparam logic [BeatW-1:0] BeatsExp = BeatW'(ResultBeats);

    logic [2:0]       state;
    op_e              cur_op;
    logic [3:0]       cur_tag;
    err_e             cur_err;
    logic [TW-1:0]    timer;
    logic [BeatW-1:0] beats, beats_nxt;

    cmd_t head, wr_cmd;
    logic full, empty, push, pop;

    assign wr_cmd  = '{op: op_e'(cmd_op_i), tag: cmd_tag_i};
    // Gating on !full alone means a push is refused when full even if a pop
    // happens the same cycle.
    assign push    = cmd_valid_i && !full;
    assign pop     = (state == StIdle) && !fault_o && !empty;

    mlp_cmd_fifo #(.Depth(QDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (wr_cmd),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign beats_nxt = result_valid_i ? sat_inc(beats) : beats;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= StIdle;
            cur_op       <= OpInit;
            cur_tag      <= '0;
            cur_err      <= ErrOk;
            timer        <= '0;
            beats        <= '0;
            weights_ok_o <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        cur_op  <= head.op;
                        cur_tag <= head.tag;
                        if (head.op == OpRun && !weights_ok_o) begin
                            cur_err <= ErrNoWeights;
                            state   <= StDone;
                        end else begin
                            state   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if ((cur_op == OpInit) ? init_ready_i : start_ready_i) begin
                        timer <= '0;
                        beats <= '0;
                        state <= (cur_op == OpInit) ? StWaitInit : StWaitRun;
                    end
                end
                // timer==0 marks the guard cycle: mlp_fsm's ready may still
                // reflect the pre-handshake idle state there, so it is ignored.
                StWaitInit: begin
                    if (timer == TimerLast) begin
                        cur_err <= ErrTimeout;
                        fault_o <= 1'b1;
                        state   <= StDone;
                    end else if (timer != '0 && init_ready_i) begin
                        cur_err      <= ErrOk;
                        weights_ok_o <= 1'b1;
                        state        <= StDone;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StWaitRun: begin
                    beats <= beats_nxt;
                    if (timer == TimerLast) begin
                        cur_err <= ErrTimeout;
                        fault_o <= 1'b1;
                        state   <= StDone;
                    end else if (timer != '0 && start_ready_i) begin
                        // Include a beat arriving in the completion cycle itself.
                        cur_err <= (beats_nxt == BeatsExp) ? ErrOk : ErrBeatMismatch;
                        state   <= StDone;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o   = !full;
    assign init_valid_o  = (state == StIssue) && (cur_op == OpInit);
    assign start_valid_o = (state == StIssue) && (cur_op == OpRun);
    assign busy_o        = (state != StIdle) || !empty;
    assign done_o        = (state == StDone);
    assign done_tag_o    = done_o ? cur_tag : '0;
    assign done_err_o    = done_o ? cur_err : '0;

endmodule

// File: tb/tb_mlp_cmd_sched.sv
// Directed bench for mlp_cmd_sched with a behavioural mlp_fsm model and a
// scoreboard of expected completions (tag, err) checked as done_o fires.
module tb_mlp_cmd_sched;

    localparam int QDepth   = 4;
    localparam int RBeats   = 32;
    localparam int TmoCyc   = 100;
    localparam int InitLat  = 40;
    localparam int RunLat   = 50;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [3:0] cmd_tag;
    logic       init_valid, init_ready, start_valid, start_ready, result_valid;
    logic       busy, weights_ok, fault, done;
    logic [3:0] done_tag;
    logic [1:0] done_err;

    mlp_cmd_sched #(.QDepth(QDepth), .ResultBeats(RBeats), .TimeoutCycles(TmoCyc)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_tag_i(cmd_tag),
        .init_valid_o(init_valid), .init_ready_i(init_ready),
        .start_valid_o(start_valid), .start_ready_i(start_ready),
        .result_valid_i(result_valid),
        .busy_o(busy), .weights_ok_o(weights_ok), .fault_o(fault),
        .done_o(done), .done_tag_o(done_tag), .done_err_o(done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mlp_fsm model ----------------
    logic m_busy, m_run, m_stall;
    int   m_cnt, m_sent, m_nbeats;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_run <= 1'b0; m_cnt <= 0; m_sent <= 0;
        end else if (!m_busy) begin
            if (init_valid) begin
                m_busy <= 1'b1; m_run <= 1'b0; m_cnt <= InitLat;
            end else if (start_valid) begin
                m_busy <= 1'b1; m_run <= 1'b1; m_cnt <= RunLat; m_sent <= 0;
            end
        end else begin
            if (result_valid) m_sent <= m_sent + 1;
            if (m_cnt > 1) m_cnt <= m_cnt - 1;
            else if (!m_stall) m_busy <= 1'b0;
        end
    end

    assign init_ready   = !m_busy;
    assign start_ready  = !m_busy;
    assign result_valid = m_busy && m_run && (m_sent < m_nbeats);

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed { logic [3:0] tag; logic [1:0] err; } exp_t;
    exp_t sb[$];
    int   n_hs = 0, n_done = 0, hs_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (init_valid || start_valid) begin
                check("valid_while_model_busy", {31'b0, m_busy}, 32'd0);
                check("one_valid_only", {31'b0, init_valid && start_valid}, 32'd0);
            end
            if ((init_valid && init_ready) || (start_valid && start_ready)) begin
                n_hs++;
                hs_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_tag", {28'b0, done_tag}, {28'b0, e.tag});
                    check("done_err", {30'b0, done_err}, {30'b0, e.err});
                end
            end else begin
                check("idle_tag_err_zero", {26'b0, done_tag, done_err}, 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic op, input logic [3:0] tag, input logic [1:0] err, input bit expect_done);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("push_ready_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b1; cmd_op = op; cmd_tag = tag;
        if (expect_done) sb.push_back('{tag: tag, err: err});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"},   {31'b0, cmd_ready},   32'd1);
        check({pfx, "_init_valid"},  {31'b0, init_valid},  32'd0);
        check({pfx, "_start_valid"}, {31'b0, start_valid}, 32'd0);
        check({pfx, "_busy"},        {31'b0, busy},        32'd0);
        check({pfx, "_weights_ok"},  {31'b0, weights_ok},  32'd0);
        check({pfx, "_fault"},       {31'b0, fault},       32'd0);
        check({pfx, "_done"},        {26'b0, done, done_tag, done_err[0]}, 32'd0);
        check({pfx, "_done_err1"},   {31'b0, done_err[1]}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs0, d0, w;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_tag = 4'd0;
        m_stall = 1'b0; m_nbeats = RBeats;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // 1: RUN without weights -> immediate NO_WEIGHTS, nothing issued
        hs0 = n_hs;
        push(1'b1, 4'd3, 2'd1, 1'b1);
        @(negedge clk);
        check("t1_not_yet_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("t1_done_latency", {31'b0, done}, 32'd1);
        wait_drain();
        check("t1_no_issue", n_hs - hs0, 32'd0);
        check("t1_weights_still_0", {31'b0, weights_ok}, 32'd0);

        // 2: INIT -> single init handshake, weights_ok set
        hs0 = n_hs;
        push(1'b0, 4'd1, 2'd0, 1'b1);
        wait_drain();
        check("t2_one_handshake", n_hs - hs0, 32'd1);
        check("t2_weights_ok", {31'b0, weights_ok}, 32'd1);

        // 3: INIT then RUN back-to-back; RUN must wait for INIT completion
        push(1'b0, 4'd2, 2'd0, 1'b1);
        push(1'b1, 4'd7, 2'd0, 1'b1);
        wait_drain();

        // 4: fill FIFO while an INIT is in flight, then overflow attempt
        push(1'b0, 4'd4, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        push(1'b0, 4'd8,  2'd0, 1'b1);
        push(1'b1, 4'd9,  2'd0, 1'b1);
        push(1'b1, 4'd10, 2'd0, 1'b1);
        push(1'b0, 4'd11, 2'd0, 1'b1);
        @(negedge clk);
        check("t4_full_ready_low", {31'b0, cmd_ready}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd1);
        push(1'b1, 4'd12, 2'd0, 1'b1);
        wait_drain();

        // 5: model stalls after accepting INIT -> timeout on 100th wait cycle
        m_stall = 1'b1;
        push(1'b0, 4'd13, 2'd2, 1'b1);
        push(1'b1, 4'd14, 2'd0, 1'b0);
        push(1'b0, 4'd15, 2'd0, 1'b0);
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("t5_timeout_seen", {31'b0, (w < 500)}, 32'd1);
        check("t5_timeout_latency", done_cyc - hs_cyc, TmoCyc + 1);
        @(negedge clk);
        check("t5_fault", {31'b0, fault}, 32'd1);
        check("t5_weights_kept", {31'b0, weights_ok}, 32'd1);
        hs0 = n_hs; d0 = n_done;
        repeat (150) @(negedge clk);
        check("t5_no_more_issue", n_hs - hs0, 32'd0);
        check("t5_no_more_done", n_done - d0, 32'd0);
        check("t5_busy_queued", {31'b0, busy}, 32'd1);

        // 6: reset clears fault; beat mismatch; reset mid-RUN aborts silently
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        m_stall = 1'b0;
        #1 check_reset_outputs("reset2");
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        push(1'b0, 4'd1, 2'd0, 1'b1);
        wait_drain();
        m_nbeats = RBeats - 1;
        push(1'b1, 4'd5, 2'd3, 1'b1);
        wait_drain();
        m_nbeats = RBeats;
        hs0 = n_hs;
        push(1'b1, 4'd6, 2'd0, 1'b1);
        w = 0;
        while (n_hs == hs0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("t6_run_issued", {31'b0, (n_hs != hs0)}, 32'd1);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1 check_reset_outputs("reset_mid_run");
        d0 = n_done;
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_done_after_abort", n_done - d0, 32'd0);
        check("t6_idle_after_abort", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
